state_code_monitor: RTL and testbench
=====================================

Name: state_code_monitor

Overview:
- Downstream consumer of the user-encoded sequencer's registered state code (the 2 LSBs of its data_out bus).
- Samples the code every clock and detects each code change.
- For each change, records an event of previous code, new code and dwell time (cycles the previous code was held).
- Buffers events in a small FIFO with a valid/ready output handshake, so a slow reader (bus bridge, logger) can drain them.

Parameters:
- CODE_W, 2, width of monitored state code.
- DWELL_W, 8, width of dwell counter / event dwell field (saturating).
- DEPTH_LOG2, 2, FIFO depth = 2**DEPTH_LOG2 entries (default 4).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); release is synchronous to clk by the system.
- code_in  input  CODE_W  state code from sequencer, sampled every rising edge.
- evt_ready  input  1  reader accepts head event this cycle.
- clear_ovf  input  1  synchronous one-cycle pulse clearing the sticky overflow flag.
- evt_valid  output  1  FIFO non-empty; head event presented.
- evt_prev  output  CODE_W  code held before the change.
- evt_code  output  CODE_W  code after the change.
- evt_dwell  output  DWELL_W  cycles evt_prev was held; saturates at all-ones.
- fill  output  DEPTH_LOG2+1  number of stored events (0..DEPTH).
- overflow  output  1  sticky; an event was dropped because the FIFO was full.

Behaviour:
- Reset (reset=0, asynchronous):
  - primed=0, code_q=0, dwell_cnt=0, FIFO pointers=0.
  - Outputs: evt_valid=0, fill=0, overflow=0; evt_prev, evt_code and evt_dwell read 0.
- Priming: first rising edge with reset=1 and primed=0 sets code_q<=code_in, dwell_cnt<=1, primed<=1. No event is generated.
- Primed, per edge:
  - If code_in==code_q: dwell_cnt<=min(dwell_cnt+1, 2**DWELL_W-1).
  - Else: push {prev=code_q, code=code_in, dwell=dwell_cnt}; then code_q<=code_in and dwell_cnt<=1.
- Dwell definition: a code sampled on N consecutive edges reports dwell N (saturated).
- Latency: a change sampled at edge t is pushed at edge t. If the FIFO was empty, evt_valid=1 and the head fields are valid right after edge t (1-cycle latency).
- FIFO and handshake:
  - First-word-fall-through: head fields are combinational from the read pointer and are stable while evt_valid=1 and evt_ready=0.
  - Pop occurs on an edge with evt_valid=1 and evt_ready=1.
  - evt_ready while empty is ignored.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by the fill count.
- Boundary conditions:
  - Push while full with no pop: event dropped, FIFO unchanged, overflow<=1.
  - Push and pop on the same edge while full: both happen, fill unchanged, no overflow.
  - Push and pop on the same edge while fill=1: new event becomes head, fill stays 1, evt_valid stays 1.
  - clear_ovf on the same edge as a drop: set wins, overflow stays 1.
  - Dwell saturation: dwell_cnt holds at 2**DWELL_W-1 and the event reports that value.
- Reset mid-operation: all stored events are discarded, primed=0, and the next post-reset edge re-primes (no spurious event from the old code_q).
- Only compare, saturate and pointer logic; no arithmetic beyond +1. No combinational path from code_in to any output.

Test Plan:
- Release reset with code_in=01 held 1 edge, then 10 for 5 edges, then 11 -> events (prev=01, code=10, dwell=1) and (prev=10, code=11, dwell=5); evt_valid rises 1 cycle after each change.
- evt_ready=0, code toggles 00/01 every edge for 6 changes -> fill climbs 1,2,3,4; 5th and 6th events dropped; overflow=1; head still holds the 1st event. Then clear_ovf pulse -> overflow=0.
- FIFO full, evt_ready=1 on the same edge as a new change -> fill stays 4, overflow stays 0, head advances to the 2nd event.
- Code constant for 300 edges then changes (DWELL_W=8) -> evt_dwell=255.
- Assert reset with fill=3 mid-stream, release with code_in=11 -> evt_valid=0, fill=0, overflow=0; the first post-reset edge produces no event; a later change to 00 reports prev=11 with the correct dwell.
- evt_ready=1 continuously, with the reader applying a 1-cycle gap between changes -> each event popped the edge after it appears, and fill never exceeds 1.

Source files
------------

// File: rtl/state_code_monitor.sv
// state_code_monitor
// Watches a sequencer state code, turns every code change into an event
// {previous code, new code, dwell cycles} and queues events in a small
// first-word-fall-through FIFO drained through a valid/ready handshake.
module state_code_monitor #(
    parameter int CODE_W     = 2,
    parameter int DWELL_W    = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CODE_W-1:0]     code_in,
    input  logic                  evt_ready,
    input  logic                  clear_ovf,
    output logic                  evt_valid,
    output logic [CODE_W-1:0]     evt_prev,
    output logic [CODE_W-1:0]     evt_code,
    output logic [DWELL_W-1:0]    evt_dwell,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  overflow
);

    localparam int DEPTH   = 2 ** DEPTH_LOG2;
    localparam int ENTRY_W = 2 * CODE_W + DWELL_W;
    localparam logic [DEPTH_LOG2:0] FILL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef logic [ENTRY_W-1:0] entry_t;

    typedef enum logic {
        ST_UNPRIMED,
        ST_PRIMED
    } state_t;

    state_t                  state_q;
    logic [CODE_W-1:0]       code_q;
    logic [DWELL_W-1:0]      dwell_cnt;

    entry_t                  mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     fill_q;
    logic                    ovf_q;

    logic                    changed;
    logic                    full;
    logic                    do_pop;
    logic                    do_push;
    logic                    drop;
    entry_t                  new_entry;
    entry_t                  head;

    // Change detection and FIFO accept/drop decisions for this edge.
    always_comb begin
        changed   = (state_q == ST_PRIMED) && (code_in != code_q);
        full      = (fill_q == FILL_FULL);
        do_pop    = (fill_q != '0) && evt_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        do_push   = changed && (!full || do_pop);
        drop      = changed && full && !do_pop;
        new_entry = {code_q, code_in, dwell_cnt};
    end

    // Priming, code tracking and saturating dwell counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_UNPRIMED;
            code_q    <= '0;
            dwell_cnt <= '0;
        end else begin
            case (state_q)
                ST_UNPRIMED: begin
                    state_q   <= ST_PRIMED;
                    code_q    <= code_in;
                    dwell_cnt <= DWELL_W'(1);
                end
                ST_PRIMED: begin
                    if (changed) begin
                        code_q    <= code_in;
                        dwell_cnt <= DWELL_W'(1);
                    end else if (dwell_cnt != '1) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                default: state_q <= ST_UNPRIMED;
            endcase
        end
    end

    // FIFO pointers, occupancy count and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Event storage; contents are only observable through the gated head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    // Head presentation; fields read zero whenever the FIFO is empty.
    always_comb begin
        head      = (fill_q != '0) ? mem[rd_ptr] : '0;
        evt_valid = (fill_q != '0);
        evt_prev  = head[ENTRY_W-1 -: CODE_W];
        evt_code  = head[DWELL_W +: CODE_W];
        evt_dwell = head[DWELL_W-1:0];
        fill      = fill_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_state_code_monitor.sv
// tb_state_code_monitor
// Directed-vector bench for state_code_monitor with hand-computed expectations.
module tb_state_code_monitor;

    logic       clk;
    logic       reset;
    logic [1:0] code_in;
    logic       evt_ready;
    logic       clear_ovf;
    logic       evt_valid;
    logic [1:0] evt_prev;
    logic [1:0] evt_code;
    logic [7:0] evt_dwell;
    logic [2:0] fill;
    logic       overflow;

    int tests_run;
    int tests_failed;

    state_code_monitor #(
        .CODE_W     (2),
        .DWELL_W    (8),
        .DEPTH_LOG2 (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .evt_ready (evt_ready),
        .clear_ovf (clear_ovf),
        .evt_valid (evt_valid),
        .evt_prev  (evt_prev),
        .evt_code  (evt_code),
        .evt_dwell (evt_dwell),
        .fill      (fill),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_head(input string tag, input int prev, input int code, input int dwell);
        check({tag, ".valid"}, 32'(evt_valid), 32'd1);
        check({tag, ".prev"},  32'(evt_prev),  32'(prev));
        check({tag, ".code"},  32'(evt_code),  32'(code));
        check({tag, ".dwell"}, 32'(evt_dwell), 32'(dwell));
    endtask

    // Advance one rising edge, returning shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset     = 1'b0;
        code_in   = 2'b01;
        evt_ready = 1'b0;
        clear_ovf = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst.valid", 32'(evt_valid), 32'd0);
        check("rst.fill",  32'(fill),      32'd0);
        check("rst.ovf",   32'(overflow),  32'd0);
        check("rst.prev",  32'(evt_prev),  32'd0);
        check("rst.code",  32'(evt_code),  32'd0);
        check("rst.dwell", 32'(evt_dwell), 32'd0);

        // Basic events: 01 x1, 10 x5, then 11
        reset = 1'b1;
        tick();                                  // prime with 01
        check("prime.valid", 32'(evt_valid), 32'd0);
        code_in = 2'b10;
        tick();
        check_head("ev1", 1, 2, 1);
        repeat (4) tick();
        check("ev1.fill", 32'(fill), 32'd1);
        code_in = 2'b11;
        tick();
        check("ev2.fill", 32'(fill), 32'd2);
        check_head("ev2.headkeep", 1, 2, 1);
        evt_ready = 1'b1;
        tick();
        check_head("ev2", 2, 3, 5);
        check("ev2.fillpop", 32'(fill), 32'd1);
        tick();
        check("drain.valid", 32'(evt_valid), 32'd0);
        check("drain.fill",  32'(fill),      32'd0);
        evt_ready = 1'b0;

        // Settle on 00 with an empty FIFO
        code_in = 2'b00;
        tick();
        check_head("ev3", 3, 0, 3);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("ev3.fill", 32'(fill), 32'd0);

        // Fill to full, then two dropped events
        for (int i = 1; i <= 6; i++) begin
            code_in = (i % 2 == 1) ? 2'b01 : 2'b00;
            tick();
            check($sformatf("tog%0d.fill", i), 32'(fill), (i > 4) ? 32'd4 : 32'(i));
            check($sformatf("tog%0d.ovf", i), 32'(overflow), (i >= 5) ? 32'd1 : 32'd0);
        end
        check_head("full.head", 0, 1, 2);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clr.ovf",  32'(overflow), 32'd0);
        check("clr.fill", 32'(fill),     32'd4);

        // Full FIFO: push and pop on the same edge
        code_in   = 2'b01;
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pp.fill", 32'(fill),     32'd4);
        check("pp.ovf",  32'(overflow), 32'd0);
        check_head("pp.head", 1, 0, 1);

        // Drop coinciding with clear_ovf: set wins
        code_in   = 2'b00;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("dropclr.ovf",  32'(overflow), 32'd1);
        check("dropclr.fill", 32'(fill),     32'd4);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        check("clr2.ovf", 32'(overflow), 32'd0);

        // Drain
        evt_ready = 1'b1;
        tick();
        check_head("drain1", 0, 1, 1);
        repeat (3) tick();
        evt_ready = 1'b0;
        check("drain2.valid", 32'(evt_valid), 32'd0);
        check("drain2.fill",  32'(fill),      32'd0);

        // Dwell saturation
        repeat (300) tick();
        code_in = 2'b01;
        tick();
        check_head("sat", 0, 1, 255);
        evt_ready = 1'b1;
        tick();
        check("sat.fill", 32'(fill), 32'd0);

        // Continuous reader, one gap cycle between changes
        for (int k = 0; k < 4; k++) begin
            logic [1:0] prev_c;
            logic [1:0] next_c;
            prev_c  = code_in;
            next_c  = code_in + 2'b01;
            code_in = next_c;
            tick();
            check($sformatf("gap%0d.fill", k), 32'(fill), 32'd1);
            check_head($sformatf("gap%0d", k), int'(prev_c), int'(next_c), 2);
            tick();
            check($sformatf("gap%0d.popfill", k), 32'(fill), 32'd0);
        end

        // Push and pop at fill=1: new event becomes head
        code_in = 2'b10;
        tick();
        check_head("p1a", 1, 2, 2);
        code_in = 2'b11;
        tick();
        check("p1b.fill", 32'(fill), 32'd1);
        check_head("p1b", 2, 3, 1);
        tick();
        evt_ready = 1'b0;
        check("p1c.fill", 32'(fill), 32'd0);

        // Reset mid-stream with three stored events
        code_in = 2'b00;
        tick();
        code_in = 2'b01;
        tick();
        code_in = 2'b00;
        tick();
        check("mid.fill", 32'(fill), 32'd3);
        #2;
        reset = 1'b0;
        #1;
        check("mrst.valid", 32'(evt_valid), 32'd0);
        check("mrst.fill",  32'(fill),      32'd0);
        check("mrst.ovf",   32'(overflow),  32'd0);
        code_in = 2'b11;
        tick();
        tick();
        reset = 1'b1;
        tick();                                  // re-prime with 11
        check("reprime.valid", 32'(evt_valid), 32'd0);
        check("reprime.fill",  32'(fill),      32'd0);
        repeat (3) tick();
        code_in = 2'b00;
        tick();
        check_head("postrst", 3, 0, 4);
        check("postrst.fill", 32'(fill), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
